// File: rtl/sweep_pkg.sv
// Shared types and constants for the up/down sweep sequencer.
package sweep_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} sweep_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam int   LEG_W    = 4;
endpackage

// File: rtl/updown_cnt.sv
// WIDTH-bit synchronous up/down counter with parallel load; clear is active-low.
module updown_cnt
  import sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (en) begin
      r_q <= (m == DIR_DOWN) ? r_q - 1'b1 : r_q + 1'b1;
    end
  end

  assign q = r_q;
endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweeps an up/down counter between latched bounds for a set number of legs or continuously.
// Define SWEEP_HOLD_EN to dwell HOLD_CYCLES cycles at each intermediate turning point.
module updown_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [3:0]       passes,
  output logic [WIDTH-1:0] q,
  output logic             m,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  sweep_state_e     r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [LEG_W-1:0] r_passes;
  logic [LEG_W-1:0] r_legs;
  logic             r_m;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
`ifdef SWEEP_HOLD_EN
  logic [3:0]       r_dwell;
`else
  logic             w_unused_hold;
  assign w_unused_hold = ^HOLD_LAST;
`endif

  logic [WIDTH-1:0] w_q;
  logic [LEG_W-1:0] w_legs_next;
  logic             w_at_hi;
  logic             w_at_lo;
  logic             w_leg_end;
  logic             w_final;
  logic             w_start_ok;
  logic             w_cnt_en;
  logic             w_cnt_dir;
  logic             w_cnt_load;

  assign w_at_hi     = (w_q == r_hi);
  assign w_at_lo     = (w_q == r_lo);
  assign w_leg_end   = ((r_state == UP) && w_at_hi) || ((r_state == DOWN) && w_at_lo);
  assign w_legs_next = r_legs + 1'b1;
  assign w_final     = w_leg_end && (r_passes != '0) && (w_legs_next == r_passes);
  assign w_start_ok  = (r_state == IDLE) && start && !stop && (lo < hi);

  // Counter controls: a turn steps away from the endpoint on the same edge m toggles.
  always_comb begin
    w_cnt_en   = 1'b0;
    w_cnt_dir  = r_m;
    w_cnt_load = 1'b0;
    if (clear) begin
      if (w_start_ok) begin
        w_cnt_load = 1'b1;
      end else if (!stop) begin
        case (r_state)
          UP: begin
            if (!w_at_hi) begin
              w_cnt_en  = 1'b1;
              w_cnt_dir = DIR_UP;
            end
`ifndef SWEEP_HOLD_EN
            else if (!w_final) begin
              w_cnt_en  = 1'b1;
              w_cnt_dir = DIR_DOWN;
            end
`endif
          end
          DOWN: begin
            if (!w_at_lo) begin
              w_cnt_en  = 1'b1;
              w_cnt_dir = DIR_DOWN;
            end
`ifndef SWEEP_HOLD_EN
            else if (!w_final) begin
              w_cnt_en  = 1'b1;
              w_cnt_dir = DIR_UP;
            end
`endif
          end
`ifdef SWEEP_HOLD_EN
          HOLD: begin
            if (r_dwell == '0) begin
              w_cnt_en  = 1'b1;
              w_cnt_dir = ~r_m;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .clear (clear),
    .en    (w_cnt_en),
    .m     (w_cnt_dir),
    .load  (w_cnt_load),
    .d     (lo),
    .q     (w_q)
  );

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_passes <= '0;
      r_legs   <= '0;
      r_m      <= DIR_UP;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef SWEEP_HOLD_EN
      r_dwell  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if ((r_state != IDLE) && stop) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !stop) begin
              if (lo < hi) begin
                r_lo     <= lo;
                r_hi     <= hi;
                r_passes <= passes;
                r_legs   <= '0;
                r_m      <= DIR_UP;
                r_busy   <= 1'b1;
                r_state  <= UP;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          UP, DOWN: begin
            if (w_leg_end) begin
              r_legs <= w_legs_next;
              if (w_final) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
`ifdef SWEEP_HOLD_EN
                r_state <= HOLD;
                r_dwell <= HOLD_LAST;
`else
                r_m     <= ~r_m;
                r_state <= (r_state == UP) ? DOWN : UP;
`endif
              end
            end
          end
`ifdef SWEEP_HOLD_EN
          HOLD: begin
            if (r_dwell == '0) begin
              r_m     <= ~r_m;
              r_state <= (r_m == DIR_UP) ? DOWN : UP;
            end else begin
              r_dwell <= r_dwell - 1'b1;
            end
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign q    = w_q;
  assign m    = r_m;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl; the HOLD scenario runs only when SWEEP_HOLD_EN is defined.
module tb_updown_sweep_ctrl;
  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] passes;
  logic [3:0] q;
  logic       m;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  updown_sweep_ctrl #(.WIDTH(4), .HOLD_CYCLES(2)) dut (
    .clk    (clk),
    .clear  (clear),
    .start  (start),
    .stop   (stop),
    .lo     (lo),
    .hi     (hi),
    .passes (passes),
    .q      (q),
    .m      (m),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int eq, input int em, input int eb,
                            input int ed, input int ee);
    check_val({tag, ".q"},    32'(q),    32'(eq));
    check_val({tag, ".m"},    32'(m),    32'(em));
    check_val({tag, ".busy"}, 32'(busy), 32'(eb));
    check_val({tag, ".done"}, 32'(done), 32'(ed));
    check_val({tag, ".err"},  32'(err),  32'(ee));
  endtask

  initial begin
    int exp_q2[7];
    int exp_m2[7];
    int p;
    int eq;
    int em;
    exp_q2 = '{2, 3, 4, 5, 4, 3, 2};
    exp_m2 = '{0, 0, 0, 0, 1, 1, 1};

    // reset with start held high
    clear = 1'b0; start = 1'b1; stop = 1'b0; lo = 4'd3; hi = 4'd7; passes = 4'd1;
    tick();
    tick();
    check_outs("reset", 0, 0, 0, 0, 0);
    clear = 1'b1; start = 1'b0;
    tick();
    check_outs("post_reset", 0, 0, 0, 0, 0);
    $display("reset: q=%0d busy=%0d", q, busy);

    // two-leg sweep 2..5; bound changes mid-sweep must be ignored
    lo = 4'd2; hi = 4'd5; passes = 4'd2; start = 1'b1;
    tick();
    start = 1'b0; lo = 4'd0; hi = 4'd9; passes = 4'd0;
    for (int i = 0; i < 7; i++) begin
      check_outs($sformatf("sweep2[%0d]", i), exp_q2[i], exp_m2[i], 1, 0, 0);
      tick();
    end
    check_outs("sweep2.done", 2, 1, 0, 1, 0);
    tick();
    check_outs("sweep2.after", 2, 1, 0, 0, 0);
    $display("sweep lo=2 hi=5 passes=2: end q=%0d", q);

    // rejected start lo == hi
    lo = 4'd5; hi = 4'd5; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("err", 2, 1, 0, 0, 1);
    tick();
    check_outs("err.after", 2, 1, 0, 0, 0);
    $display("start lo=5 hi=5: err seen");

    // stop and start together in IDLE: start ignored
    lo = 4'd0; hi = 4'd3; passes = 4'd1; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_outs("stop_start", 2, 1, 0, 0, 0);
    $display("start+stop in idle: ignored");

    // continuous 0..15 for 21 full legs, then stop at q=9 going down
    lo = 4'd0; hi = 4'd15; passes = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 321; t++) begin
      p  = t % 30;
      eq = (p <= 15) ? p : 30 - p;
      em = (p == 0) ? ((t != 0) ? 1 : 0) : ((p > 15) ? 1 : 0);
      if (t % 15 == 0 || t >= 320) begin
        check_outs($sformatf("cont[t=%0d]", t), eq, em, 1, 0, 0);
      end else begin
        check_val($sformatf("cont[t=%0d].q", t), 32'(q), 32'(eq));
      end
      if (t == 321) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    check_outs("cont.stop", 9, 1, 0, 0, 0);
    tick();
    check_outs("cont.stop.after", 9, 1, 0, 0, 0);
    $display("continuous 0..15: stopped at q=%0d", q);

    // single leg ending on hi, then back-to-back start in the done cycle
    lo = 4'd1; hi = 4'd4; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("leg1[%0d]", i), 1 + i, 0, 1, 0, 0);
      tick();
    end
    check_outs("leg1.done", 4, 0, 0, 1, 0);
    lo = 4'd0; hi = 4'd1; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("b2b[0]", 0, 0, 1, 0, 0);
    tick();
    check_outs("b2b[1]", 1, 0, 1, 0, 0);
    tick();
    check_outs("b2b.done", 1, 0, 0, 1, 0);
    tick();
    check_outs("b2b.after", 1, 0, 0, 0, 0);
    $display("back-to-back lo=0 hi=1: end q=%0d", q);

`ifdef SWEEP_HOLD_EN
    begin
      int exp_qh[7];
      int exp_mh[7];
      exp_qh = '{1, 2, 3, 3, 3, 2, 1};
      exp_mh = '{0, 0, 0, 0, 0, 1, 1};
      lo = 4'd1; hi = 4'd3; passes = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
        check_outs($sformatf("hold[%0d]", i), exp_qh[i], exp_mh[i], 1, 0, 0);
        tick();
      end
      check_outs("hold.done", 1, 1, 0, 1, 0);
      $display("hold sweep lo=1 hi=3: end q=%0d", q);
    end
`endif

    // reset mid-sweep
    lo = 4'd3; hi = 4'd9; passes = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_outs("midrst.pre", 5, 0, 1, 0, 0);
    clear = 1'b0;
    tick();
    clear = 1'b1;
    check_outs("midrst", 0, 0, 0, 0, 0);
    $display("reset mid-sweep: q=%0d busy=%0d", q, busy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencer for the team's up/down counter datapath. It loads the counter with a lower bound and drives its direction input (`m`) so the count sweeps back and forth between a programmable lower and upper bound. It runs either a fixed number of legs or continuously until stopped. It sits between software/test control logic and the counter, and owns all count-enable, load and direction decisions.

## Interface
Parameters:
- `WIDTH`, default 4: count width, matching the counter datapath.
- `HOLD_CYCLES`, default 2: dwell cycles at each turning point. Used only with `SWEEP_HOLD_EN`; valid range 1..15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `clear`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: sweep request. Accepted only in IDLE.
- `stop`, input, 1: abort request. Honoured in any state.
- `lo`, input, WIDTH: lower bound. Sampled on start acceptance.
- `hi`, input, WIDTH: upper bound. Sampled on start acceptance.
- `passes`, input, 4: number of legs to run. 0 means continuous. Sampled on start acceptance.
- `q`, output, WIDTH: current count.
- `m`, output, 1: direction. 0 = up, 1 = down. Same encoding as the counter's mode input.
- `busy`, output, 1: high while a sweep is active (UP, DOWN, HOLD).
- `done`, output, 1: one-cycle pulse when the final leg completes.
- `err`, output, 1: one-cycle pulse when a start is rejected because `lo >= hi`.

## Operation
- **States:** IDLE, UP, DOWN, HOLD. HOLD exists only with `SWEEP_HOLD_EN`.
- **Reset** (`clear` = 0 at an edge): state IDLE, `q` = 0, `m` = 0, `busy` = 0, `done` = 0, `err` = 0, leg counter = 0.
- **IDLE + start, `lo < hi`:** latch `lo`, `hi`, `passes`. Then `q` ← `lo`, `m` ← 0, leg counter ← 0, go to UP.
- **IDLE + start, `lo >= hi`:** `err` pulses; remain in IDLE; `q` unchanged.
- **UP:**
  - While `q != hi`: `q` ← `q + 1`.
  - At `q == hi`, one leg completes; leg counter increments.
- **DOWN:**
  - While `q != lo`: `q` ← `q - 1`.
  - At `q == lo`, one leg completes; leg counter increments.
- **Leg completion:**
  - If `passes != 0` and the completed leg count equals `passes`: go to IDLE, `done` pulses, `q` holds the endpoint, `m` holds.
  - Otherwise, reverse direction. `m` toggles and `q` steps away from the endpoint on the same edge, so the endpoint is never repeated without HOLD.
- **Continuous mode** (`passes == 0`):
  - The leg counter wraps modulo 16 and is not compared.
  - The sweep ends only on `stop` or reset.
- **Stop:** in any non-IDLE state, next edge goes to IDLE. `q` and `m` freeze; no `done` pulse.
- **Priority:** reset > stop > start > sweep progress. If `stop` and `start` are both high in IDLE, start is ignored.
- **Input changes:** `start` held high while busy has no effect. `lo`, `hi` and `passes` changes during a sweep are ignored.
- **Arithmetic:** `lo < hi` guarantees that no wrap-around ever occurs. Comparisons are unsigned, WIDTH bits.

## Timing
- Start accepted at edge N: `q = lo`, `m = 0`, `busy = 1` at N+1.
- Each leg lasts `hi - lo` cycles (plus `HOLD_CYCLES` at the turn with the macro).
- `done` is high exactly one cycle, the cycle after the final endpoint is shown. `busy` falls in that same cycle.
- `err` is high exactly one cycle, the cycle after the rejected start.
- Back-to-back: a new start is accepted in the same cycle `done` is high.
- Reset mid-sweep: outputs take reset values one edge later, regardless of state.

## Configuration
`SWEEP_HOLD_EN`:
- **Defined:**
  - On reaching a turning endpoint that does not end the sweep, go to HOLD.
  - In HOLD, `q` holds for `HOLD_CYCLES` cycles, then `m` toggles and the sweep resumes in the opposite direction.
  - `stop` in HOLD behaves as in UP/DOWN.
  - The final endpoint never enters HOLD.
- **Undefined:** no HOLD state and no dwell counter; `HOLD_CYCLES` is ignored.

## Structure
- **Package `sweep_pkg`:** state enum (IDLE, UP, DOWN, HOLD), direction constants `DIR_UP = 0` and `DIR_DOWN = 1`, leg counter width constant (4).
- **Sub-module `updown_cnt`:** WIDTH-bit synchronous up/down counter with `en`, `m`, `load`, `d` inputs, driven by the controller FSM. The FSM, bounds latch, leg counter and dwell counter stay in `updown_sweep_ctrl`.

## Test plan
- Reset check: `clear` low for 2 cycles with `start` high → `q` = 0, `m` = 0, `busy` = 0, no `done`/`err`.
- `lo` = 2, `hi` = 5, `passes` = 2, no macro → `q` = 2,3,4,5,4,3,2. Then `done` pulses one cycle with `q` = 2 and `busy` = 0.
- `lo` = 5, `hi` = 5, start → `err` pulses one cycle; `busy` stays 0; `q` unchanged.
- `passes` = 0, `lo` = 0, `hi` = 15 → sweep runs longer than 20 legs. Assert `stop` while `q` = 9 in DOWN → next cycle IDLE with `q` = 9, `m` = 1, no `done`.
- `SWEEP_HOLD_EN`, `HOLD_CYCLES` = 2, `lo` = 1, `hi` = 3, `passes` = 2 → `q` = 1,2,3,3,3,2,1, then `done`.
- `done` cycle with a new `start` (`lo` = 0, `hi` = 1, `passes` = 1) → `q` = 0 next cycle, then `q` = 1, then `done`.
